// File: rtl/mem_resp.sv
// Line-store memory responder: accepts one line read/write per request, completes after LATENCY access cycles.
// mem_complete pulses in cycle LATENCY+1 after mem_req rises; a still-held request parks in RELEASE until it drops.
module mem_resp #(
    parameter int LATENCY = 4,
    parameter int IDX_W   = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_req,
    input  logic         mem_rw,
    input  logic [25:0]  mem_addr,
    input  logic [511:0] mem_wd,
    output logic         mem_complete,
    output logic [511:0] mem_rd,
    output logic         mem_busy,
    output logic [15:0]  rd_cnt,
    output logic [15:0]  wr_cnt
);

    localparam int         LINES  = 2 ** IDX_W;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               rw_q;
    logic [IDX_W-1:0]   idx_q;
    logic [511:0]       wd_q;
    logic [511:0]       rd_q;
    logic [15:0]        rd_cnt_q;
    logic [15:0]        wr_cnt_q;
    logic               accept;
    logic               finish;

    // Storage is deliberately left out of reset so contents survive a reset.
    logic [511:0]       mem_q [LINES];

    // Upper address bits alias onto the same lines.
    generate
        if (IDX_W < 26) begin : g_alias
            logic unused_addr_hi;
            assign unused_addr_hi = ^mem_addr[25:IDX_W];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    accept  = 1'b1;
                    cnt_d   = LAT_M1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = mem_req ? RELEASE : IDLE;
            end
            RELEASE: begin
                if (!mem_req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            rw_q     <= 1'b0;
            idx_q    <= '0;
            wd_q     <= '0;
            rd_q     <= '0;
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                rw_q  <= mem_rw;
                idx_q <= mem_addr[IDX_W-1:0];
                wd_q  <= mem_wd;
            end
            if (finish && !rw_q) begin
                rd_q <= mem_q[idx_q];
                if (rd_cnt_q != 16'hFFFF) begin
                    rd_cnt_q <= rd_cnt_q + 16'd1;
                end
            end
            if (finish && rw_q) begin
                if (wr_cnt_q != 16'hFFFF) begin
                    wr_cnt_q <= wr_cnt_q + 16'd1;
                end
            end
        end
    end

    // Reset on the ACCESS->DONE edge must suppress the array write.
    always_ff @(posedge clk) begin
        if (!rst && finish && rw_q) begin
            mem_q[idx_q] <= wd_q;
        end
    end

    assign mem_complete = (state_q == DONE);
    assign mem_busy     = (state_q != IDLE);
    assign mem_rd       = rd_q;
    assign rd_cnt       = rd_cnt_q;
    assign wr_cnt       = wr_cnt_q;

endmodule

// File: tb/tb_mem_resp.sv
// Directed bench for mem_resp with LATENCY=4, IDX_W=8.
module tb_mem_resp;

    logic         clk;
    logic         rst;
    logic         mem_req;
    logic         mem_rw;
    logic [25:0]  mem_addr;
    logic [511:0] mem_wd;
    logic         mem_complete;
    logic [511:0] mem_rd;
    logic         mem_busy;
    logic [15:0]  rd_cnt;
    logic [15:0]  wr_cnt;

    int tests;
    int fails;

    logic [511:0] dat_a;
    logic [511:0] dat_b;
    logic [511:0] dat_c;
    logic [511:0] dat_d;
    logic [511:0] dat_e;
    logic [511:0] dat_f;

    mem_resp #(.LATENCY(4), .IDX_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_req      (mem_req),
        .mem_rw       (mem_rw),
        .mem_addr     (mem_addr),
        .mem_wd       (mem_wd),
        .mem_complete (mem_complete),
        .mem_rd       (mem_rd),
        .mem_busy     (mem_busy),
        .rd_cnt       (rd_cnt),
        .wr_cnt       (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raises mem_req in cycle 0 and returns the cycle index in which complete was seen;
    // leaves the DUT in DONE with mem_req still high.
    task automatic start_wait(input logic rw, input logic [25:0] addr, input logic [511:0] wd,
                              output int n);
        mem_rw   = rw;
        mem_addr = addr;
        mem_wd   = wd;
        mem_req  = 1'b1;
        n = 0;
        while (!mem_complete && n < 30) begin
            tick();
            n++;
        end
    endtask

    // Full transaction with mem_req dropped during the DONE cycle; ends in IDLE.
    task automatic run_txn(input logic rw, input logic [25:0] addr, input logic [511:0] wd,
                           output int n);
        start_wait(rw, addr, wd, n);
        mem_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests++; if (mem_complete !== 1'b0) begin fails++; $display("FAIL reset_complete got=%0b exp=0", mem_complete); end
        tests++; if (mem_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%0b exp=0", mem_busy); end
        tests++; if (mem_rd !== 512'h0) begin fails++; $display("FAIL reset_rd got=%h exp=0", mem_rd[31:0]); end
        tests++; if (rd_cnt !== 16'd0) begin fails++; $display("FAIL reset_rd_cnt got=%0d exp=0", rd_cnt); end
        tests++; if (wr_cnt !== 16'd0) begin fails++; $display("FAIL reset_wr_cnt got=%0d exp=0", wr_cnt); end
    endtask

    task automatic test_write_read();
        int n;
        run_txn(1'b1, 26'h05, dat_a, n);
        tests++; if (n !== 5) begin fails++; $display("FAIL wr_latency got=%0d exp=5", n); end
        tests++; if (wr_cnt !== 16'd1) begin fails++; $display("FAIL wr_cnt got=%0d exp=1", wr_cnt); end
        tests++; if (mem_rd !== 512'h0) begin fails++; $display("FAIL wr_rd_unchanged got=%h exp=0", mem_rd[31:0]); end
        tests++; if (mem_busy !== 1'b0) begin fails++; $display("FAIL wr_idle_busy got=%0b exp=0", mem_busy); end
        start_wait(1'b0, 26'h05, '0, n);
        tests++; if (n !== 5) begin fails++; $display("FAIL rd_latency got=%0d exp=5", n); end
        tests++; if (mem_rd !== dat_a) begin fails++; $display("FAIL rd_data got=%h exp=%h", mem_rd[31:0], dat_a[31:0]); end
        tests++; if (rd_cnt !== 16'd1) begin fails++; $display("FAIL rd_cnt got=%0d exp=1", rd_cnt); end
        mem_req = 1'b0;
        tick();
    endtask

    task automatic test_held_request();
        int n;
        int pulses;
        int not_busy;
        start_wait(1'b0, 26'h05, '0, n);
        pulses = 0;
        not_busy = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_complete) pulses++;
            if (!mem_busy) not_busy++;
        end
        tests++; if (pulses !== 0) begin fails++; $display("FAIL held_extra_pulses got=%0d exp=0", pulses); end
        tests++; if (not_busy !== 0) begin fails++; $display("FAIL held_busy_drop got=%0d exp=0", not_busy); end
        tests++; if (rd_cnt !== 16'd2) begin fails++; $display("FAIL held_rd_cnt got=%0d exp=2", rd_cnt); end
        mem_req = 1'b0;
        tick();
        tests++; if (mem_busy !== 1'b0) begin fails++; $display("FAIL held_release_busy got=%0b exp=0", mem_busy); end
    endtask

    task automatic test_mid_change();
        int n;
        run_txn(1'b1, 26'h06, dat_b, n);
        mem_rw   = 1'b0;
        mem_addr = 26'h05;
        mem_req  = 1'b1;
        tick();
        mem_addr = 26'h06;
        mem_rw   = 1'b1;
        mem_wd   = dat_c;
        n = 1;
        while (!mem_complete && n < 30) begin
            tick();
            n++;
        end
        tests++; if (mem_rd !== dat_a) begin fails++; $display("FAIL mid_rd_data got=%h exp=%h", mem_rd[31:0], dat_a[31:0]); end
        tests++; if (wr_cnt !== 16'd2) begin fails++; $display("FAIL mid_wr_cnt got=%0d exp=2", wr_cnt); end
        tests++; if (rd_cnt !== 16'd3) begin fails++; $display("FAIL mid_rd_cnt got=%0d exp=3", rd_cnt); end
        mem_req = 1'b0;
        tick();
        run_txn(1'b0, 26'h06, '0, n);
        tests++; if (mem_rd !== dat_b) begin fails++; $display("FAIL mid_no_write got=%h exp=%h", mem_rd[31:0], dat_b[31:0]); end
    endtask

    task automatic test_reset_abort();
        int n;
        int pulses;
        run_txn(1'b1, 26'h07, dat_d, n);
        // Abort in the middle of ACCESS.
        mem_rw = 1'b1; mem_addr = 26'h07; mem_wd = dat_e; mem_req = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mem_complete) pulses++;
        end
        rst = 1'b1;
        tick();
        if (mem_complete) pulses++;
        rst = 1'b0;
        mem_req = 1'b0;
        tests++; if (pulses !== 0) begin fails++; $display("FAIL abort_pulse got=%0d exp=0", pulses); end
        tests++; if (mem_busy !== 1'b0) begin fails++; $display("FAIL abort_busy got=%0b exp=0", mem_busy); end
        tests++; if (mem_rd !== 512'h0) begin fails++; $display("FAIL abort_rd got=%h exp=0", mem_rd[31:0]); end
        tests++; if (rd_cnt !== 16'd0 || wr_cnt !== 16'd0) begin fails++; $display("FAIL abort_cnts got=%0d/%0d exp=0/0", rd_cnt, wr_cnt); end
        // Abort exactly on the ACCESS->DONE edge.
        mem_req = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_complete) pulses++;
        end
        rst = 1'b1;
        tick();
        if (mem_complete) pulses++;
        rst = 1'b0;
        mem_req = 1'b0;
        tick();
        if (mem_complete) pulses++;
        tests++; if (pulses !== 0) begin fails++; $display("FAIL abort_edge_pulse got=%0d exp=0", pulses); end
        tests++; if (wr_cnt !== 16'd0) begin fails++; $display("FAIL abort_edge_wr_cnt got=%0d exp=0", wr_cnt); end
        run_txn(1'b0, 26'h07, '0, n);
        tests++; if (mem_rd !== dat_d) begin fails++; $display("FAIL abort_storage got=%h exp=%h", mem_rd[31:0], dat_d[31:0]); end
        tests++; if (rd_cnt !== 16'd1) begin fails++; $display("FAIL abort_rd_cnt got=%0d exp=1", rd_cnt); end
    endtask

    task automatic test_alias();
        int n;
        run_txn(1'b1, 26'h105, dat_f, n);
        run_txn(1'b0, 26'h005, '0, n);
        tests++; if (mem_rd !== dat_f) begin fails++; $display("FAIL alias_data got=%h exp=%h", mem_rd[31:0], dat_f[31:0]); end
        tests++; if (wr_cnt !== 16'd1) begin fails++; $display("FAIL alias_wr_cnt got=%0d exp=1", wr_cnt); end
    endtask

    task automatic test_back_to_back();
        int n;
        start_wait(1'b0, 26'h06, '0, n);
        tick();
        mem_req = 1'b0;
        tick();
        tests++; if (mem_busy !== 1'b0) begin fails++; $display("FAIL b2b_idle got=%0b exp=0", mem_busy); end
        start_wait(1'b0, 26'h05, '0, n);
        tests++; if (n !== 5) begin fails++; $display("FAIL b2b_latency got=%0d exp=5", n); end
        tests++; if (mem_rd !== dat_f) begin fails++; $display("FAIL b2b_data got=%h exp=%h", mem_rd[31:0], dat_f[31:0]); end
        mem_req = 1'b0;
        tick();
    endtask

    // Preloads the read counter near its limit rather than issuing 65536 reads.
    task automatic test_saturation();
        int n;
        force dut.rd_cnt_q = 16'hFFFD;
        #2;
        release dut.rd_cnt_q;
        tests++; if (rd_cnt !== 16'hFFFD) begin fails++; $display("FAIL sat_preload got=%h exp=fffd", rd_cnt); end
        run_txn(1'b0, 26'h05, '0, n);
        tests++; if (rd_cnt !== 16'hFFFE) begin fails++; $display("FAIL sat_step got=%h exp=fffe", rd_cnt); end
        run_txn(1'b0, 26'h05, '0, n);
        tests++; if (rd_cnt !== 16'hFFFF) begin fails++; $display("FAIL sat_reach got=%h exp=ffff", rd_cnt); end
        run_txn(1'b0, 26'h05, '0, n);
        run_txn(1'b0, 26'h05, '0, n);
        tests++; if (rd_cnt !== 16'hFFFF) begin fails++; $display("FAIL sat_hold got=%h exp=ffff", rd_cnt); end
        tests++; if (wr_cnt !== 16'd1) begin fails++; $display("FAIL sat_wr_cnt got=%0d exp=1", wr_cnt); end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        dat_a    = {16{32'hA5A5_0001}};
        dat_b    = {16{32'h0B0B_0006}};
        dat_c    = {16{32'hC0C0_0066}};
        dat_d    = {16{32'hD0D0_0007}};
        dat_e    = {16{32'hEEEE_0077}};
        dat_f    = {16{32'hF1F1_0105}};
        rst      = 1'b1;
        mem_req  = 1'b0;
        mem_rw   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        test_reset();
        test_write_read();
        test_held_request();
        test_mid_change();
        test_reset_abort();
        test_alias();
        test_back_to_back();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_resp.md
MEM_RESP -- requirements
Module: mem_resp

Interface
REQ-001 SHALL have parameter LATENCY, default 4, array-access cycles per transaction, legal range 1..15.
REQ-002 SHALL have parameter IDX_W, default 8, line-index width; storage is 2**IDX_W lines of 512 bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port mem_req  input  1  request from L2, level, held high until mem_complete is seen.
REQ-006 SHALL have port mem_rw  input  1  0 = read line, 1 = write line.
REQ-007 SHALL have port mem_addr  input  26  line address (64-byte line).
REQ-008 SHALL have port mem_wd  input  512  write line data.
REQ-009 SHALL have port mem_complete  output  1  one-cycle completion pulse.
REQ-010 SHALL have port mem_rd  output  512  read line data, registered.
REQ-011 SHALL have port mem_busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port rd_cnt  output  16  completed-read counter, saturating.
REQ-013 SHALL have port wr_cnt  output  16  completed-write counter, saturating.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, DONE, RELEASE.
REQ-015 SHALL, in IDLE with mem_req=1, latch mem_rw, mem_addr[IDX_W-1:0] and mem_wd, load latency counter with LATENCY-1, and go to ACCESS.
REQ-016 SHALL ignore mem_rw, mem_addr, mem_wd changes after the accept edge until the next accept.
REQ-017 SHALL, in ACCESS, decrement the counter each cycle and go to DONE on the edge where the counter is 0; ACCESS lasts exactly LATENCY cycles.
REQ-018 SHALL, on the ACCESS->DONE edge, for a read load mem_rd from the latched line; for a write store the latched data into the latched line with mem_rd unchanged.
REQ-019 SHALL drive mem_complete=1 only during the single DONE cycle; with mem_req first high in cycle 0, mem_complete is high in cycle LATENCY+1.
REQ-020 SHALL increment rd_cnt or wr_cnt on the ACCESS->DONE edge per latched mem_rw, holding at 16'hFFFF when saturated.
REQ-021 SHALL go from DONE to IDLE if mem_req=0, else to RELEASE; RELEASE returns to IDLE only when mem_req=0, so a still-held request is never served twice.
REQ-022 SHALL hold mem_rd stable across writes and idle cycles until the next read completes.
REQ-023 SHALL alias addresses: mem_addr bits above IDX_W-1 are ignored.
REQ-024 SHALL return the newly written data for a read following a write to the same index (no stale data).
REQ-025 SHALL keep mem_complete combinationally independent of inputs (decoded from state only).

Reset
REQ-026 SHALL, with rst=1 at an edge, set state IDLE, counter 0, mem_complete 0, mem_busy 0, mem_rd 512'h0, rd_cnt 0, wr_cnt 0.
REQ-027 SHALL give rst priority over every transition; a transaction in progress is aborted with no mem_complete and no array write, even if the edge is the ACCESS->DONE edge.
REQ-028 SHALL NOT clear storage contents on reset.

Verification
REQ-029 Write then read, LATENCY=4: req write addr 0x05 data {16{32'hA5A5_0001}} cycle 0 -> complete pulse cycle 5, wr_cnt=1; then read 0x05 -> mem_rd={16{32'hA5A5_0001}} with complete, rd_cnt=1.
REQ-030 Held request: mem_req kept high 10 cycles after complete -> exactly one complete pulse, FSM in RELEASE until req drops, mem_busy=1 throughout.
REQ-031 Mid-transaction input change: after accept of read 0x05, change mem_addr to 0x06 and mem_rw to 1 -> read of 0x05 returned, no write to 0x06, wr_cnt unchanged.
REQ-032 Reset abort: write 0x07 accepted, rst=1 at cycle 3 -> no complete, all outputs reset values, later read 0x07 returns pre-write contents.
REQ-033 Aliasing and saturation: write 0x105 (IDX_W=8) then read 0x005 -> written data returned; force 65536 reads -> rd_cnt holds 16'hFFFF.
REQ-034 Back-to-back: req drops the cycle after complete and rises the next cycle -> new accept from IDLE, second complete LATENCY+1 cycles after re-assertion.
